// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge/level capture, mask, priority, claim/EOI.
// Optional IRQ_LEVEL_EN adds the MODE register for level-sensitive sources.
module irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_ren,
    input  logic               bus_wen,
    input  logic [31:0]        bus_addr,
    input  logic [31:0]        bus_din,
    output logic [31:0]        bus_dout,
    output logic               bus_hit,
    output logic               interrupter,
    output logic [4:0]         irq_id
);

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_CLAIM = 3'd2;
    localparam logic [2:0] OFF_EOI   = 3'd3;
    localparam logic [2:0] OFF_MODE  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } state_t;

    state_t state_q;
    logic   interrupter_q;

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_src_q, prev_src_d;
    logic [4:0]         in_service_q, in_service_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [31:0]        bus_dout_q, bus_dout_d;
    logic               bus_hit_q, bus_hit_d;
`ifdef IRQ_LEVEL_EN
    logic [NUM_SRC-1:0] mode_q, mode_d;
`endif

    logic               sel;
    logic [2:0]         off;
    logic               rd_en;
    logic               wr_en;
    logic               claim;
    logic               eoi;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clear;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] eligible;
    logic [31:0]        rdata;

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_din[31:NUM_SRC]};

    always_comb begin
        sel   = (bus_addr[31:5] == BASE_ADDR[31:5]);
        off   = bus_addr[4:2];
        rd_en = bus_ren & sel;
        wr_en = bus_wen & sel;
        claim = rd_en && (off == OFF_CLAIM) && (irq_id_q != 5'd0);
        eoi   = wr_en && (off == OFF_EOI);
    end

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim && (irq_id_q == 5'(i + 1))) begin
                claim_clr[i] = 1'b1;
            end
        end
        clear = claim_clr;
        if (wr_en && (off == OFF_PEND)) begin
            clear = clear | bus_din[NUM_SRC-1:0];
        end
        rise       = irq_src & ~prev_src_q;
        prev_src_d = irq_src;
        // A rise in the same cycle as a clear keeps the bit set.
        pending_d  = (pending_q & ~clear) | rise;
`ifdef IRQ_LEVEL_EN
        pending_d  = (pending_d & ~mode_q) | (irq_src & mode_q);
`endif
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (off == OFF_MASK)) begin
            mask_d = bus_din[NUM_SRC-1:0];
        end
`ifdef IRQ_LEVEL_EN
        mode_d = mode_q;
        if (wr_en && (off == OFF_MODE)) begin
            mode_d = bus_din[NUM_SRC-1:0];
        end
`endif
        in_service_d = in_service_q;
        if (eoi) begin
            in_service_d = 5'd0;
        end else if (claim) begin
            in_service_d = irq_id_q;
        end
    end

    always_comb begin
        eligible = pending_q & mask_q;
        irq_id_d = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_id_d = 5'(i + 1);
            end
        end
    end

    // Read data always reflects pre-write register contents.
    always_comb begin
        case (off)
            OFF_PEND:  rdata = 32'(pending_q);
            OFF_MASK:  rdata = 32'(mask_q);
            OFF_CLAIM: rdata = 32'(irq_id_q);
            OFF_EOI:   rdata = 32'(in_service_q);
`ifdef IRQ_LEVEL_EN
            OFF_MODE:  rdata = 32'(mode_q);
`endif
            default:   rdata = 32'd0;
        endcase
        bus_hit_d  = rd_en;
        bus_dout_d = rd_en ? rdata : bus_dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            mask_q       <= '0;
            prev_src_q   <= '0;
            in_service_q <= 5'd0;
            irq_id_q     <= 5'd0;
            bus_dout_q   <= 32'd0;
            bus_hit_q    <= 1'b0;
`ifdef IRQ_LEVEL_EN
            mode_q       <= '0;
`endif
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            prev_src_q   <= prev_src_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
            bus_dout_q   <= bus_dout_d;
            bus_hit_q    <= bus_hit_d;
`ifdef IRQ_LEVEL_EN
            mode_q       <= mode_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            interrupter_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        state_q       <= ASSERT;
                        interrupter_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (claim) begin
                        state_q       <= SERVICE;
                        interrupter_q <= 1'b0;
                    end else if (eligible == '0) begin
                        state_q       <= IDLE;
                        interrupter_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_q <= IDLE;
                    end
                    interrupter_q <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    interrupter_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_dout    = bus_dout_q;
    assign bus_hit     = bus_hit_q;
    assign interrupter = interrupter_q;
    assign irq_id      = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: reads queue expectations, a monitor checks bus_hit data.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        bus_hit;
    logic        interrupter;
    logic [4:0]  irq_id;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    irq_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .irq_src(irq_src),
        .bus_ren(bus_ren),
        .bus_wen(bus_wen),
        .bus_addr(bus_addr),
        .bus_din(bus_din),
        .bus_dout(bus_dout),
        .bus_hit(bus_hit),
        .interrupter(interrupter),
        .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!rst && bus_hit) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got %h, none expected", bus_dout);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus_dout !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got %h expected %h", bus_dout, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        bus_wen  = 1'b1;
        bus_addr = BASE + 32'(off);
        bus_din  = d;
        tick();
        bus_wen  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] e);
        bus_ren  = 1'b1;
        bus_addr = BASE + 32'(off);
        exp_q.push_back(e);
        tick();
        bus_ren  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        irq_src  = 8'h00;
        bus_ren  = 1'b0;
        bus_wen  = 1'b0;
        bus_addr = 32'h0;
        bus_din  = 32'h0;
        repeat (3) tick();
        chk("rst_intr", 32'(interrupter), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_hit", 32'(bus_hit), 0);
        chk("rst_dout", bus_dout, 0);
        rst = 1'b0;

        // masked capture
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        rd(8'h00, 32'h08);
        chk("t1_intr", 32'(interrupter), 0);
        chk("t1_id", 32'(irq_id), 0);
        wr(8'h00, 32'h08);

        // two sources, claim highest priority
        wr(8'h04, 32'hFF);
        irq_src = 8'h28;
        tick();
        irq_src = 8'h00;
        tick();
        chk("t2_intr", 32'(interrupter), 1);
        chk("t2_id", 32'(irq_id), 4);
        rd(8'h08, 32'd4);
        rd(8'h00, 32'h20);
        chk("t2_svc_intr", 32'(interrupter), 0);
        rd(8'h0C, 32'd4);

        // EOI, reassert for source 5
        wr(8'h0C, 32'h0);
        tick();
        chk("t3_intr", 32'(interrupter), 1);
        chk("t3_id", 32'(irq_id), 6);
        rd(8'h08, 32'd6);
        wr(8'h0C, 32'h0);
        tick();
        tick();
        chk("t3_idle_intr", 32'(interrupter), 0);
        chk("t3_idle_id", 32'(irq_id), 0);

        // held source captures once; set beats W1C
        irq_src = 8'h04;
        repeat (10) tick();
        rd(8'h00, 32'h04);
        wr(8'h00, 32'h04);
        rd(8'h00, 32'h00);
        irq_src = 8'h00;
        tick();
        irq_src = 8'h04;
        wr(8'h00, 32'h04);
        rd(8'h00, 32'h04);
        chk("t4_intr", 32'(interrupter), 1);
        chk("t4_id", 32'(irq_id), 3);
        irq_src = 8'h00;
        wr(8'h00, 32'h04);
        tick();
        tick();
        chk("t4_clr_intr", 32'(interrupter), 0);

        // decode corners
        rd(8'h14, 32'h0);
        bus_ren  = 1'b1;
        bus_addr = 32'h0000_1000;
        tick();
        bus_ren  = 1'b0;
        chk("t5_hit_out", 32'(bus_hit), 0);
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h05, 32'hFF);
        wr(8'h04, 32'hFF);
`ifndef IRQ_LEVEL_EN
        wr(8'h10, 32'h1);
        rd(8'h10, 32'h0);
`else
        // level-sensitive source 0
        wr(8'h10, 32'h1);
        rd(8'h10, 32'h1);
        irq_src = 8'h01;
        repeat (3) tick();
        chk("t6_intr", 32'(interrupter), 1);
        chk("t6_id", 32'(irq_id), 1);
        rd(8'h08, 32'd1);
        chk("t6_svc_intr", 32'(interrupter), 0);
        rd(8'h00, 32'h01);
        wr(8'h0C, 32'h0);
        tick();
        chk("t6_reassert", 32'(interrupter), 1);
        irq_src = 8'h00;
        wr(8'h00, 32'h01);
        tick();
        tick();
        chk("t6_drop_intr", 32'(interrupter), 0);
        rd(8'h00, 32'h00);
`endif

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
